// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC, picks trap/jump-register/branch/sequential next address,
// buffers redirects across stalls, traps misaligned targets and pulses flush.
module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter int               INSTR_BYTES  = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'('h80)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             trap,
  input  logic             jumpReg,
  input  logic [WIDTH-1:0] jumpAddress,
  input  logic             branch,
  input  logic [WIDTH-1:0] branchAddress,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] nextPC,
  output logic             pending,
  output logic             flush,
  output logic             misaligned
);
  localparam logic [WIDTH-1:0] MASK = WIDTH'(INSTR_BYTES - 1);
  localparam logic [WIDTH-1:0] STEP = WIDTH'(INSTR_BYTES);
  typedef enum logic [1:0] {SRC_BR, SRC_JR, SRC_TRAP} src_e;
  logic [WIDTH-1:0] pc_q, pc_d, buf_q, buf_d, jr_tgt, br_tgt, win_tgt;
  src_e             src_q, src_d, win_src;
  logic             pend_q, pend_d, flush_q, flush_d, mis_q, mis_d;
  logic             jr_mis, br_mis, win_mis, redirect;
  // address inputs only matter when their request is asserted
  assign jr_mis   = jumpReg && |(jumpAddress & MASK);
  assign br_mis   = branch && |(branchAddress & MASK);
  assign jr_tgt   = jr_mis ? TRAP_VECTOR : jumpAddress;
  assign br_tgt   = br_mis ? TRAP_VECTOR : branchAddress;
  assign redirect = trap || jumpReg || branch;
  assign win_tgt  = trap ? TRAP_VECTOR : jumpReg ? jr_tgt : branch ? br_tgt : pc_q + STEP;
  assign win_mis  = !trap && (jumpReg ? jr_mis : br_mis);
  assign win_src  = trap ? SRC_TRAP : jumpReg ? SRC_JR : SRC_BR;
  always_comb begin
    pc_d    = pc_q;
    pend_d  = pend_q;
    buf_d   = buf_q;
    src_d   = src_q;
    flush_d = 1'b0;
    mis_d   = 1'b0;
    if (stall && !pend_q) begin
      if (redirect) begin
        pend_d = 1'b1;
        buf_d  = win_tgt;
        src_d  = win_src;
        mis_d  = win_mis;
      end
    end else if (stall) begin
      // a buffered trap is never displaced; a buffered branch yields to trap or jumpReg
      if (trap) begin
        buf_d = TRAP_VECTOR;
        src_d = SRC_TRAP;
      end else if (jumpReg && src_q == SRC_BR) begin
        buf_d = jr_tgt;
        src_d = SRC_JR;
        mis_d = jr_mis;
      end
    end else if (pend_q) begin
      pc_d    = trap ? TRAP_VECTOR : buf_q;
      pend_d  = 1'b0;
      flush_d = 1'b1;
    end else begin
      pc_d    = win_tgt;
      flush_d = redirect;
      mis_d   = win_mis;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_VECTOR;
      pend_q  <= 1'b0;
      buf_q   <= '0;
      src_q   <= SRC_BR;
      flush_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      buf_q   <= buf_d;
      src_q   <= src_d;
      flush_q <= flush_d;
      mis_q   <= mis_d;
    end
  end
  assign PC         = pc_q;
  assign nextPC     = pc_d;
  assign pending    = pend_q;
  assign flush      = flush_q;
  assign misaligned = mis_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus randomized run against a rank-based reference model.
module tb_pc_sequencer;
  logic        clk = 1'b0, reset = 1'b0, stall = 1'b0, trap = 1'b0;
  logic        jumpReg = 1'b0, branch = 1'b0;
  logic [31:0] jumpAddress = '0, branchAddress = '0;
  logic [31:0] PC, nextPC;
  logic        pending, flush, misaligned;
  int          checks = 0, errors = 0;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .trap(trap),
    .jumpReg(jumpReg), .jumpAddress(jumpAddress),
    .branch(branch), .branchAddress(branchAddress),
    .PC(PC), .nextPC(nextPC), .pending(pending),
    .flush(flush), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic t, input logic j, input logic [31:0] ja,
                       input logic b, input logic [31:0] ba);
    stall = s; trap = t; jumpReg = j; jumpAddress = ja; branch = b; branchAddress = ba;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #2;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    checks++;
    if (PC !== 32'h0 || pending !== 1'b0 || flush !== 1'b0 || misaligned !== 1'b0) begin
      errors++;
      $display("FAIL reset_state PC=%h pend=%b flush=%b mis=%b want 0/0/0/0", PC, pending, flush, misaligned);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (PC !== 32'(4 * i) || flush !== 1'b0) begin
        errors++;
        $display("FAIL seq_%0d PC=%h flush=%b want %h/0", i, PC, flush, 4 * i);
      end
    end
    drive(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (PC !== 32'h0 || flush !== 1'b0) begin
      errors++;
      $display("FAIL wrap PC=%h flush=%b want 0/0", PC, flush);
    end
  endtask

  task automatic test_stall_branch();
    do_reset();
    tick(); tick();
    drive(1, 0, 0, 0, 1, 32'd20);
    #1;
    checks++;
    if (nextPC !== 32'd8) begin
      errors++;
      $display("FAIL stall_nextpc nextPC=%h want 8", nextPC);
    end
    tick(); tick();
    checks++;
    if (PC !== 32'd8 || pending !== 1'b1 || flush !== 1'b0) begin
      errors++;
      $display("FAIL stall_hold PC=%h pend=%b flush=%b want 8/1/0", PC, pending, flush);
    end
    drive(0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (nextPC !== 32'd20) begin
      errors++;
      $display("FAIL release_nextpc nextPC=%h want 14", nextPC);
    end
    tick();
    checks++;
    if (PC !== 32'd20 || flush !== 1'b1 || pending !== 1'b0) begin
      errors++;
      $display("FAIL release PC=%h flush=%b pend=%b want 14/1/0", PC, flush, pending);
    end
    tick();
    checks++;
    if (PC !== 32'd24 || flush !== 1'b0) begin
      errors++;
      $display("FAIL release_after PC=%h flush=%b want 18/0", PC, flush);
    end
  endtask

  task automatic test_priority();
    do_reset();
    drive(0, 0, 1, 32'd20, 0, 0);
    tick();
    drive(0, 1, 1, 32'd40, 1, 32'd200);
    tick();
    checks++;
    if (PC !== 32'h80 || flush !== 1'b1 || misaligned !== 1'b0) begin
      errors++;
      $display("FAIL prio_trap PC=%h flush=%b mis=%b want 80/1/0", PC, flush, misaligned);
    end
    drive(0, 0, 1, 32'd40, 1, 32'd200);
    tick();
    checks++;
    if (PC !== 32'd40 || flush !== 1'b1) begin
      errors++;
      $display("FAIL prio_jr PC=%h flush=%b want 28/1", PC, flush);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (PC !== 32'd44 || flush !== 1'b0) begin
      errors++;
      $display("FAIL prio_after PC=%h flush=%b want 2c/0", PC, flush);
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    drive(0, 0, 1, 32'd42, 0, 0);
    tick();
    checks++;
    if (PC !== 32'h80 || misaligned !== 1'b1 || flush !== 1'b1) begin
      errors++;
      $display("FAIL mis_direct PC=%h mis=%b flush=%b want 80/1/1", PC, misaligned, flush);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (PC !== 32'h84 || misaligned !== 1'b0 || flush !== 1'b0) begin
      errors++;
      $display("FAIL mis_pulse PC=%h mis=%b flush=%b want 84/0/0", PC, misaligned, flush);
    end
    drive(1, 0, 0, 0, 1, 32'd22);
    tick();
    checks++;
    if (misaligned !== 1'b1 || pending !== 1'b1 || PC !== 32'h84) begin
      errors++;
      $display("FAIL mis_capture mis=%b pend=%b PC=%h want 1/1/84", misaligned, pending, PC);
    end
    drive(1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (PC !== 32'h80 || misaligned !== 1'b0 || flush !== 1'b1) begin
      errors++;
      $display("FAIL mis_once PC=%h mis=%b flush=%b want 80/0/1", PC, misaligned, flush);
    end
  endtask

  task automatic test_buffer_override();
    for (int r = 0; r < 2; r++) begin
      do_reset();
      drive(1, 0, 0, 0, 1, 32'd20);
      tick();
      drive(1, 0, 1, 32'd60, 0, 0);
      tick();
      drive(1, 0, 0, 0, 1, 32'd100);
      tick();
      drive(0, r == 1, 0, 0, 0, 0);
      tick();
      checks++;
      if (PC !== (r == 1 ? 32'h80 : 32'd60) || flush !== 1'b1 || pending !== 1'b0) begin
        errors++;
        $display("FAIL override_%0d PC=%h flush=%b pend=%b want %h/1/0", r, PC, flush, pending,
                 r == 1 ? 32'h80 : 32'd60);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick();
    drive(1, 0, 0, 0, 1, 32'd20);
    tick();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (PC !== 32'h0 || pending !== 1'b0) begin
      errors++;
      $display("FAIL async_reset PC=%h pend=%b want 0/0", PC, pending);
    end
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    checks++;
    if (PC !== 32'h4 || flush !== 1'b0 || pending !== 1'b0) begin
      errors++;
      $display("FAIL async_after PC=%h flush=%b pend=%b want 4/0/0", PC, flush, pending);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 7);
    if (r == 0) return $urandom() | 32'h1;
    if (r == 1) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
    return $urandom() & 32'hFFFF_FFFC;
  endfunction

  // Reference: redirects carry a rank (branch 1, jump 2, trap 3); a buffered
  // redirect is replaced only by a strictly higher-ranked one while stalled.
  task automatic test_random();
    logic [31:0] m_pc, m_buf, n_pc, tgt;
    int          m_rank, k;
    logic        m_pend, n_flush, n_mis, bad;
    do_reset();
    m_pc = 0; m_buf = 0; m_rank = 0; m_pend = 0;
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
            rand_addr(), $urandom_range(0, 3) == 0, rand_addr());
      #1;
      k   = trap ? 3 : jumpReg ? 2 : branch ? 1 : 0;
      tgt = k == 3 ? 32'h80 : k == 2 ? jumpAddress : k == 1 ? branchAddress : m_pc + 4;
      bad = (k == 1 || k == 2) && (tgt % 4 != 0);
      if (bad) tgt = 32'h80;
      n_pc = m_pc; n_flush = 0; n_mis = 0;
      if (stall) begin
        if ((!m_pend && k != 0) || (m_pend && k > m_rank)) begin
          m_buf = tgt; m_rank = k; n_mis = bad;
        end
        m_pend = m_pend || k != 0;
      end else if (m_pend) begin
        n_pc = trap ? 32'h80 : m_buf; m_pend = 0; m_rank = 0; n_flush = 1;
      end else begin
        n_pc = tgt; n_flush = k != 0; n_mis = bad;
      end
      checks++;
      if (nextPC !== n_pc) begin
        errors++;
        $display("FAIL rand_nextpc[%0d] nextPC=%h want %h", i, nextPC, n_pc);
      end
      tick();
      m_pc = n_pc;
      checks++;
      if (PC !== m_pc || pending !== m_pend || flush !== n_flush || misaligned !== n_mis) begin
        errors++;
        $display("FAIL rand_state[%0d] PC=%h pend=%b flush=%b mis=%b want %h/%b/%b/%b",
                 i, PC, pending, flush, misaligned, m_pc, m_pend, n_flush, n_mis);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_branch();
    test_priority();
    test_misaligned();
    test_buffer_override();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
